// File: rtl/sbox_sched.sv
// Arbitrates state-matrix (4 words) and key-word substitution jobs onto one
// shared combinational 32-bit sbox word unit, round-robin on contention.
module sbox_sched (
    input  logic         clk,
    input  logic         reset,
    input  logic         st_req,
    input  logic [127:0] st_in,
    output logic         st_ack,
    output logic         st_done,
    output logic [127:0] st_out,
    input  logic         key_req,
    input  logic [31:0]  key_in,
    output logic         key_ack,
    output logic         key_done,
    output logic [31:0]  key_out,
    output logic [31:0]  sb_in,
    input  logic [31:0]  sb_out,
    output logic         busy
);

    localparam int unsigned WORD_W    = 32;
    localparam int unsigned STATE_W   = 128;
    localparam int unsigned BUF_W     = STATE_W - WORD_W;
    localparam int unsigned CNT_W     = 2;
    localparam int unsigned LAST_WORD = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        STW  = 2'd1,
        KEYW = 2'd2
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic               last_key_q;
    logic [BUF_W-1:0]   st_buf_q;
    logic [WORD_W-1:0]  sb_word_q;
    logic               last_word;

    assign last_word = (cnt_q == CNT_W'(LAST_WORD));

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and grant; a tie goes to whichever side was not served last
    always_comb begin
        state_d = state_q;
        st_ack  = 1'b0;
        key_ack = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!reset) begin
                    if (st_req && (!key_req || last_key_q)) begin
                        st_ack = 1'b1;
                    end else if (key_req) begin
                        key_ack = 1'b1;
                    end
                end
                if (st_ack) begin
                    state_d = STW;
                end else if (key_ack) begin
                    state_d = KEYW;
                end
            end
            STW: begin
                if (last_word) begin
                    state_d = IDLE;
                end
            end
            KEYW: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Datapath: sb_word_q is preloaded so the shared unit sees each word
    // in the cycle its result is captured.
    always_ff @(posedge clk) begin
        if (reset) begin
            st_out     <= '0;
            key_out    <= '0;
            st_done    <= 1'b0;
            key_done   <= 1'b0;
            st_buf_q   <= '0;
            sb_word_q  <= '0;
            cnt_q      <= '0;
            last_key_q <= 1'b1;
        end else begin
            st_done  <= 1'b0;
            key_done <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (st_ack) begin
                        sb_word_q  <= st_in[STATE_W-1 -: WORD_W];
                        st_buf_q   <= st_in[BUF_W-1:0];
                        cnt_q      <= '0;
                        last_key_q <= 1'b0;
                    end else if (key_ack) begin
                        sb_word_q  <= key_in;
                        last_key_q <= 1'b1;
                    end
                end
                STW: begin
                    unique case (cnt_q)
                        2'd0:    st_out[127:96] <= sb_out;
                        2'd1:    st_out[95:64]  <= sb_out;
                        2'd2:    st_out[63:32]  <= sb_out;
                        default: st_out[31:0]   <= sb_out;
                    endcase
                    // Buffer drains to zero, so sb_word_q returns to 0 after the last word
                    sb_word_q <= st_buf_q[BUF_W-1 -: WORD_W];
                    st_buf_q  <= {st_buf_q[BUF_W-WORD_W-1:0], WORD_W'(0)};
                    cnt_q     <= CNT_W'(cnt_q + 1'b1);
                    if (last_word) begin
                        st_done <= 1'b1;
                    end
                end
                KEYW: begin
                    key_out   <= sb_out;
                    key_done  <= 1'b1;
                    sb_word_q <= '0;
                end
                default: begin
                    sb_word_q <= '0;
                end
            endcase
        end
    end

    assign sb_in = reset ? WORD_W'(0) : sb_word_q;
    assign busy  = !reset && (state_q != IDLE);

    a_ack_excl: assert property (@(posedge clk) disable iff (reset) !(st_ack && key_ack));
    a_done_excl: assert property (@(posedge clk) disable iff (reset) !(st_done && key_done));

endmodule

// File: doc/sbox_sched.md
SBOX_SCHED -- requirements
Module: sbox_sched

Interface
REQ-001 SHALL: clk, input, 1, single clock; all state updates on its rising edge.
REQ-002 SHALL: reset, input, 1, synchronous, active-high reset.
REQ-003 SHALL: st_req, input, 1, state path requests 128-bit byte substitution.
REQ-004 SHALL: st_in, input, 128, state matrix to substitute; sampled only on acceptance.
REQ-005 SHALL: st_ack, output, 1, state request accepted this cycle.
REQ-006 SHALL: st_done, output, 1, one-cycle pulse; st_out valid.
REQ-007 SHALL: st_out, output, 128, substituted state matrix.
REQ-008 SHALL: key_req, input, 1, key expansion requests 32-bit word substitution.
REQ-009 SHALL: key_in, input, 32, word to substitute; sampled only on acceptance.
REQ-010 SHALL: key_ack, output, 1, key request accepted this cycle.
REQ-011 SHALL: key_done, output, 1, one-cycle pulse; key_out valid.
REQ-012 SHALL: key_out, output, 32, substituted word.
REQ-013 SHALL: sb_in, output, 32, word driven to the single shared 4-byte sbox word unit.
REQ-014 SHALL: sb_out, input, 32, combinational result of the shared word unit.
REQ-015 SHALL: busy, output, 1, high in any state other than IDLE.

Function
REQ-016 SHALL: FSM states IDLE, STW (state job, 2-bit word counter 0..3), KEYW (key job).
REQ-017 SHALL: acceptance = req && ack in the same cycle; ack is asserted only in IDLE, combinationally from req inputs and arbitration flag.
REQ-018 SHALL: at most one of st_ack/key_ack high per cycle; no ack without the matching req.
REQ-019 SHALL: single requester in IDLE granted immediately; both requesting -> grant the one not served last (flag `last`, updated on each acceptance).
REQ-020 SHALL: non-preemptive: a job in progress is never interrupted; requests arriving meanwhile wait (req must be held until ack).
REQ-021 SHALL: state job accepted in cycle T: STW cycles T+1..T+4 drive sb_in = st_in[127:96], [95:64], [63:32], [31:0] in that order; sb_out captured into the same slice of st_out each cycle.
REQ-022 SHALL: st_done high in cycle T+5 (FSM back in IDLE); new acceptance permitted in that same cycle.
REQ-023 SHALL: key job accepted in cycle T: KEYW in T+1 drives sb_in = key_in; key_out captured; key_done high in T+2 (IDLE).
REQ-024 SHALL: sb_in = 32'h0 in IDLE.
REQ-025 SHALL: st_out/key_out hold last completed result until the next completion of the same job type; partial st_out slices are not architecturally valid before st_done.
REQ-026 SHALL: done pulses last exactly one cycle; st_done and key_done never high simultaneously.
REQ-027 SHALL: sustained throughput: one state job per 5 cycles, one key job per 2 cycles, alternating under contention.

Reset
REQ-028 SHALL: reset high -> next edge: FSM IDLE, counter 0, last = key (state wins first tie), st_out = 0, key_out = 0, st_done = key_done = 0.
REQ-029 SHALL: during reset, st_ack = key_ack = 0, busy = 0, sb_in = 0.
REQ-030 SHALL: reset mid-job aborts it: no done pulse is ever issued for the aborted job; partial results discarded (outputs zeroed).

Verification
REQ-031 SHALL: st_req with st_in = 128'h0 at T -> st_ack at T, st_done at T+5, st_out = 128'h6363...63 (16 bytes of 63).
REQ-032 SHALL: key_req with key_in = 32'h000102FF at T -> key_ack at T, sb_in = 000102FF at T+1, key_done at T+2, key_out = 32'h637C7716.
REQ-033 SHALL: st_req and key_req both high in the first cycle after reset -> st_ack first, st_done at T+5 with key_ack same cycle, key_done at T+7; then with both held, alternation continues (key served after state, state after key).
REQ-034 SHALL: st_in = {4{32'h00010253}} accepted at T, reset asserted at T+2 -> no st_done, st_out = 0, busy = 0 after reset; a subsequent job completes normally.
REQ-035 SHALL: st_req held continuously with changing st_in -> acceptances at T, T+5, T+10; each st_out corresponds to the st_in sampled at its acceptance, not later values.
REQ-036 SHALL: key_req raised at T+2 during a state job -> key_ack not before T+5; random-stimulus checker confirms REQ-018/026 every cycle.
